// File: rtl/usb_rst_sequencer.sv
// Avalon-MM controlled USB host-controller reset sequencer: drives an exact-length
// reset pulse, waits a settle interval, then flags done with an optional interrupt.
module usb_rst_sequencer #(
  parameter int unsigned          CNT_W      = 16,
  parameter logic [CNT_W-1:0]     DEF_PULSE  = 16'd1000,
  parameter logic [CNT_W-1:0]     DEF_SETTLE = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_shadow_q, settle_shadow_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] settle_len_q, settle_len_d;
  logic             usb_rst_q, usb_rst_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             irq_en_q, irq_en_d;

  logic wr_en;
  logic ctrl_wr;
  logic start;
  logic abort;
  logic busy;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == 2'd0);
  assign start   = ctrl_wr & writedata[0];
  assign abort   = ctrl_wr & writedata[1];
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    settle_shadow_d = settle_shadow_q;
    pulse_len_d     = pulse_len_q;
    settle_len_d    = settle_len_q;
    usb_rst_d       = usb_rst_q;
    done_d          = done_q;
    aborted_d       = aborted_q;
    irq_en_d        = irq_en_q;

    if (ctrl_wr) irq_en_d = writedata[2];
    if (wr_en && (address == 2'd1)) pulse_len_d  = writedata[CNT_W-1:0];
    if (wr_en && (address == 2'd2)) settle_len_d = writedata[CNT_W-1:0];
    if (wr_en && (address == 2'd3)) begin
      if (writedata[0]) done_d    = 1'b0;
      if (writedata[2]) aborted_d = 1'b0;
    end

    // FSM updates come after the W1C clears so a same-cycle set wins
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d         = ST_ASSERT;
          usb_rst_d       = 1'b1;
          cnt_d           = (pulse_len_q == '0) ? '0 : pulse_len_q - CNT_W'(1);
          settle_shadow_d = settle_len_q;
          done_d          = 1'b0;
          aborted_d       = 1'b0;
        end
      end
      ST_ASSERT, ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          usb_rst_d = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == ST_ASSERT) begin
          state_d   = ST_SETTLE;
          usb_rst_d = 1'b0;
          cnt_d     = settle_shadow_q;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      settle_shadow_q <= '0;
      pulse_len_q     <= DEF_PULSE;
      settle_len_q    <= DEF_SETTLE;
      usb_rst_q       <= 1'b1;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
      irq_en_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      settle_shadow_q <= settle_shadow_d;
      pulse_len_q     <= pulse_len_d;
      settle_len_q    <= settle_len_d;
      usb_rst_q       <= usb_rst_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
      irq_en_q        <= irq_en_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {29'd0, irq_en_q, 2'b00};
      2'd1: readdata = 32'(pulse_len_q);
      2'd2: readdata = 32'(settle_len_q);
      2'd3: readdata = {27'd0, state_q, aborted_q, busy, done_q};
      default: readdata = 32'd0;
    endcase
  end

  assign usb_rst = usb_rst_q;
  assign irq     = done_q & irq_en_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Directed bench for usb_rst_sequencer: register access, pulse/settle timing,
// length latching, abort and mid-sequence reset.
module tb_usb_rst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        usb_rst;
  logic        irq;

  int n_run  = 0;
  int n_fail = 0;

  usb_rst_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .usb_rst    (usb_rst),
    .irq        (irq)
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // STATUS encodings: {state[4:3], aborted, busy, done}
  localparam logic [31:0] ST_ASSERT_BUSY = 32'h0A;
  localparam logic [31:0] ST_SETTLE_BUSY = 32'h12;

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    ticks(2);
    reset = 1'b0;

    chk_reg("rst_ctrl",   2'd0, 32'd0);
    chk_reg("rst_pulse",  2'd1, 32'd1000);
    chk_reg("rst_settle", 2'd2, 32'd5000);
    chk_reg("rst_status", 2'd3, 32'd0);
    check("rst_usb_rst", 32'(usb_rst), 32'd1);
    check("rst_irq",     32'(irq),     32'd0);

    // N=4, S=3, irq enabled; start sampled at edge k
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h4);
    chk_reg("ctrl_irq_en", 2'd0, 32'h4);
    wr(2'd0, 32'h5);
    check("t2_k_usb_rst", 32'(usb_rst), 32'd1);
    chk_reg("t2_k_status", 2'd3, ST_ASSERT_BUSY);
    ticks(3);
    check("t2_k3_usb_rst", 32'(usb_rst), 32'd1);
    tick();
    check("t2_k4_usb_rst", 32'(usb_rst), 32'd0);
    chk_reg("t2_k4_status", 2'd3, ST_SETTLE_BUSY);
    ticks(3);
    check("t2_k7_irq", 32'(irq), 32'd0);
    chk_reg("t2_k7_status", 2'd3, ST_SETTLE_BUSY);
    tick();
    check("t2_k8_irq", 32'(irq), 32'd1);
    chk_reg("t2_k8_status", 2'd3, 32'h01);
    tick();
    check("t2_idle_usb_rst", 32'(usb_rst), 32'd0);

    // W1C of done drops the interrupt
    wr(2'd3, 32'h1);
    check("t3_clr_irq", 32'(irq), 32'd0);

    // Zero lengths: one-cycle pulse, done one cycle after the fall
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h5);
    check("t3_k_usb_rst", 32'(usb_rst), 32'd1);
    tick();
    check("t3_k1_usb_rst", 32'(usb_rst), 32'd0);
    chk_reg("t3_k1_status", 2'd3, ST_SETTLE_BUSY);
    tick();
    chk_reg("t3_k2_status", 2'd3, 32'h01);
    check("t3_k2_irq", 32'(irq), 32'd1);
    wr(2'd3, 32'h1);
    chk_reg("t3_w1c_status", 2'd3, 32'h00);
    check("t3_w1c_irq", 32'(irq), 32'd0);

    // done set on the same edge as a STATUS W1C write: set wins
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h5);
    tick();
    wr(2'd3, 32'h1);
    chk_reg("t3b_set_wins", 2'd3, 32'h01);
    wr(2'd3, 32'h1);

    // Lengths latched at start; second start ignored while busy
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h5);
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h5);
    chk_reg("t4_k2_status", 2'd3, ST_ASSERT_BUSY);
    chk_reg("t4_pulse_rb",  2'd1, 32'd50);
    tick();
    check("t4_k3_usb_rst", 32'(usb_rst), 32'd1);
    tick();
    check("t4_k4_usb_rst", 32'(usb_rst), 32'd0);
    ticks(4);
    chk_reg("t4_k8_status", 2'd3, 32'h01);
    wr(2'd0, 32'h1);
    chk_reg("t4b_k_status", 2'd3, ST_ASSERT_BUSY);
    ticks(49);
    check("t4b_k49_usb_rst", 32'(usb_rst), 32'd1);
    tick();
    check("t4b_k50_usb_rst", 32'(usb_rst), 32'd0);
    ticks(4);
    chk_reg("t4b_k54_status", 2'd3, 32'h01);
    check("t4b_irq_off", 32'(irq), 32'd0);

    // Abort mid-pulse
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    ticks(4);
    wr(2'd0, 32'h2);
    check("t5_abort_usb_rst", 32'(usb_rst), 32'd1);
    chk_reg("t5_abort_status", 2'd3, 32'h04);
    wr(2'd3, 32'h4);
    chk_reg("t5_clr_aborted", 2'd3, 32'h00);
    wr(2'd0, 32'h3);
    chk_reg("t5_start_abort_idle", 2'd3, 32'h00);
    check("t5_start_abort_usb_rst", 32'(usb_rst), 32'd1);

    // Reset during SETTLE
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h5);
    ticks(5);
    chk_reg("t6_settle_status", 2'd3, ST_SETTLE_BUSY);
    check("t6_settle_usb_rst", 32'(usb_rst), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_usb_rst", 32'(usb_rst), 32'd1);
    check("t6_irq",     32'(irq),     32'd0);
    chk_reg("t6_status", 2'd3, 32'd0);
    chk_reg("t6_ctrl",   2'd0, 32'd0);
    chk_reg("t6_pulse",  2'd1, 32'd1000);
    chk_reg("t6_settle", 2'd2, 32'd5000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
